// File: rtl/reset_seq_pkg.sv
//------------------------------------------------------------------------------
// Module : reset_seq_pkg
// Brief  : Shared types for the reset sequencer (FSM state encoding).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package reset_seq_pkg;

   typedef enum logic [1:0] {
      RS_RESET   = 2'd0,
      RS_RELEASE = 2'd1,
      RS_RUN     = 2'd2,
      RS_ASSERT  = 2'd3
   } rs_state_t;

endpackage

`default_nettype wire

// File: rtl/reset_synchronizer.sv
//------------------------------------------------------------------------------
// Module : reset_synchronizer
// Brief  : Asynchronous-assert, synchronous-release reset synchroniser.
//          sync_rst_n rises on the SYNC_STAGES-th clk edge after rst_n rises.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module reset_synchronizer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic sync_rst_n
);

   logic [SYNC_STAGES-1:0] chain;

   // Clear the chain immediately on rst_n; shift 1s in once it is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sync_rst_n = chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
//------------------------------------------------------------------------------
// Module : reset_sequencer
// Brief  : Board reset in, NUM_DOMAINS domain resets out. Asserts
//          asynchronously, releases domains in index order HOLD_CYCLES apart
//          after a synchronised deassertion; soft reset re-runs the sequence.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS = 4,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   soft_rst_req,
   output logic                   soft_rst_ack,
   output logic [NUM_DOMAINS-1:0] domain_rst_n,
   output logic                   busy,
   output logic                   all_released
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam int IDX_W = $clog2(NUM_DOMAINS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

   logic                   sync_rst_n;
   rs_state_t              state;
   logic [CNT_W-1:0]       cnt;
   logic [IDX_W-1:0]       idx;
   logic [NUM_DOMAINS-1:0] release_mask;
   logic                   hold_done;
   logic                   release_now;

   reset_synchronizer #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .sync_rst_n (sync_rst_n)
   );

   // One-hot select of the domain due for release next.
   always_comb begin
      release_mask = '0;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         if (idx == IDX_W'(i)) begin
            release_mask[i] = 1'b1;
         end
      end
   end

   assign hold_done = (cnt == CNT_LAST);

   // The edge that first sees sync_rst_n high already counts as the first
   // hold cycle after E0, so with HOLD_CYCLES==1 domain 0 releases right there.
   assign release_now = ((state == RS_RESET) && sync_rst_n && (HOLD_CYCLES == 1)) ||
                        ((state == RS_RELEASE) && hold_done);

   // Sequencing FSM with all outputs taken straight from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RS_RESET;
         cnt          <= '0;
         idx          <= '0;
         domain_rst_n <= '0;
         soft_rst_ack <= 1'b0;
         busy         <= 1'b1;
         all_released <= 1'b0;
      end else begin
         soft_rst_ack <= 1'b0;
         if (release_now) begin
            domain_rst_n <= domain_rst_n | release_mask;
            idx          <= idx + IDX_W'(1);
            cnt          <= '0;
            if (idx == IDX_LAST) begin
               state        <= RS_RUN;
               all_released <= 1'b1;
               busy         <= 1'b0;
            end else begin
               state <= RS_RELEASE;
            end
         end else begin
            case (state)
               RS_RESET: begin
                  if (sync_rst_n) begin
                     cnt   <= CNT_W'(1);
                     state <= RS_RELEASE;
                  end
               end
               RS_RELEASE: begin
                  cnt <= cnt + CNT_W'(1);
               end
               RS_RUN: begin
                  if (soft_rst_req) begin
                     domain_rst_n <= '0;
                     soft_rst_ack <= 1'b1;
                     busy         <= 1'b1;
                     all_released <= 1'b0;
                     cnt          <= '0;
                     idx          <= '0;
                     state        <= RS_ASSERT;
                  end
               end
               RS_ASSERT: begin
                  if (hold_done) begin
                     cnt   <= '0;
                     state <= RS_RELEASE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state <= RS_RESET;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_reset_sequencer
// Brief  : Self-checking bench for reset_sequencer (default build and an
//          N=1/S=3/H=1 build), with a timing-formula reference model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_reset_sequencer;

   localparam int N = 4;
   localparam int S = 2;
   localparam int H = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, soft_rst_req, soft_rst_ack, busy, all_released;
   logic [N-1:0] domain_rst_n;
   logic         rst_n5, soft5, ack5, busy5, all5;
   logic [0:0]   dom5;

   int tests = 0;
   int fails = 0;

   reset_sequencer #(.NUM_DOMAINS(N), .SYNC_STAGES(S), .HOLD_CYCLES(H)) dut (
      .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req),
      .soft_rst_ack(soft_rst_ack), .domain_rst_n(domain_rst_n),
      .busy(busy), .all_released(all_released));

   reset_sequencer #(.NUM_DOMAINS(1), .SYNC_STAGES(3), .HOLD_CYCLES(1)) dut5 (
      .clk(clk), .rst_n(rst_n5), .soft_rst_req(soft5),
      .soft_rst_ack(ack5), .domain_rst_n(dom5),
      .busy(busy5), .all_released(all5));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: release times follow from E0 by plain arithmetic.
   int t        = 0;
   bit have_e0  = 0;
   int e0       = 0;
   int rise_cnt = 0;
   bit exp_ack  = 0;
   bit chk_en   = 0;
   int r_exp;

   function automatic int released(input int tt);
      if (!have_e0 || tt < e0) return 0;
      if ((tt - e0) / H >= N) return N;
      return (tt - e0) / H;
   endfunction

   always @(posedge clk) begin
      t = t + 1;
      if (rst_n) begin
         exp_ack = 0;
         if (have_e0 && released(t - 1) == N && soft_rst_req) begin
            e0      = t + H;
            exp_ack = 1;
         end else if (!have_e0) begin
            rise_cnt++;
            if (rise_cnt == S) begin
               have_e0 = 1;
               e0      = t;
            end
         end
      end
   end

   always @(negedge rst_n) begin
      have_e0  = 0;
      rise_cnt = 0;
      exp_ack  = 0;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         r_exp = released(t);
         check("model_dom",  32'(domain_rst_n), 32'((1 << r_exp) - 1));
         check("model_ack",  32'(soft_rst_ack), 32'(exp_ack));
         check("model_busy", 32'(busy),         32'(r_exp != N));
         check("model_all",  32'(all_released), 32'(r_exp == N));
         check("release_order", 32'(domain_rst_n & (domain_rst_n + 1'b1)), 32'(0));
      end
   end

   typedef struct {
      int           ofs;
      logic [N-1:0] dom;
      logic         bsy;
      logic         allr;
   } vec_t;

   vec_t vec [8];

   task automatic run_table(input int base, input string tag);
      for (int i = 0; i < 8; i++) begin
         while (t < base + vec[i].ofs) @(negedge clk);
         check({tag, "_dom"},  32'(domain_rst_n), 32'(vec[i].dom));
         check({tag, "_busy"}, 32'(busy),         32'(vec[i].bsy));
         check({tag, "_all"},  32'(all_released), 32'(vec[i].allr));
         check({tag, "_ack"},  32'(soft_rst_ack), 32'(0));
      end
   endtask

   int base;
   int tmark;

   initial begin
      vec[0] = '{15, 4'b0000, 1'b1, 1'b0};
      vec[1] = '{16, 4'b0001, 1'b1, 1'b0};
      vec[2] = '{31, 4'b0001, 1'b1, 1'b0};
      vec[3] = '{32, 4'b0011, 1'b1, 1'b0};
      vec[4] = '{47, 4'b0011, 1'b1, 1'b0};
      vec[5] = '{48, 4'b0111, 1'b1, 1'b0};
      vec[6] = '{63, 4'b0111, 1'b1, 1'b0};
      vec[7] = '{64, 4'b1111, 1'b0, 1'b1};

      rst_n = 0; soft_rst_req = 0; rst_n5 = 0; soft5 = 0;
      chk_en = 1;
      repeat (5) @(negedge clk);
      check("rst_dom",  32'(domain_rst_n), 32'(0));
      check("rst_ack",  32'(soft_rst_ack), 32'(0));
      check("rst_busy", 32'(busy),         32'(1));
      check("rst_all",  32'(all_released), 32'(0));

      // Power-on release
      #1 rst_n = 1;
      base = t + S;
      run_table(base, "poweron");

      // Soft reset from RUN
      #1 soft_rst_req = 1;
      @(negedge clk);
      tmark = t;
      check("soft_ack1", 32'(soft_rst_ack), 32'(1));
      check("soft_dom0", 32'(domain_rst_n), 32'(0));
      check("soft_busy", 32'(busy),         32'(1));
      #1 soft_rst_req = 0;
      @(negedge clk);
      check("soft_ack_once", 32'(soft_rst_ack), 32'(0));
      run_table(tmark + H, "soft");

      // Mid-release abort at E0+40
      #1 rst_n = 0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1;
      base = t + S;
      while (t < base + 40) @(negedge clk);
      #1 rst_n = 0;
      #1;
      check("abort_dom",  32'(domain_rst_n), 32'(0));
      check("abort_busy", 32'(busy),         32'(1));
      check("abort_all",  32'(all_released), 32'(0));
      #1 rst_n = 1;
      base = t + S;
      run_table(base, "abort");

      // Soft request held through the whole release sequence
      #1 rst_n = 0; soft_rst_req = 1;
      repeat (2) @(negedge clk);
      #1 rst_n = 1;
      base = t + S;
      run_table(base, "softhold");
      #1 soft_rst_req = 0;
      @(negedge clk);

      // Sub-cycle glitch while running
      #1 rst_n = 0;
      #1;
      check("glitch_dom",  32'(domain_rst_n), 32'(0));
      check("glitch_busy", 32'(busy),         32'(1));
      check("glitch_all",  32'(all_released), 32'(0));
      #2 rst_n = 1;
      base = t + S;
      run_table(base, "glitch");

      // Random soft requests and occasional glitches against the model
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         #1;
         soft_rst_req = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 0;
            #2 rst_n = 1;
         end
      end
      soft_rst_req = 0;

      // Minimal build: N=1, S=3, H=1
      @(negedge clk);
      #1 rst_n5 = 1;
      tmark = t;
      while (t < tmark + 3) @(negedge clk);
      check("n1_dom_e0",  32'(dom5),  32'(0));
      check("n1_busy_e0", 32'(busy5), 32'(1));
      while (t < tmark + 4) @(negedge clk);
      check("n1_dom_e1",  32'(dom5),  32'(1));
      check("n1_all_e1",  32'(all5),  32'(1));
      check("n1_busy_e1", 32'(busy5), 32'(0));
      check("n1_ack_e1",  32'(ack5),  32'(0));
      #1 soft5 = 1;
      @(negedge clk);
      check("n1_soft_ack", 32'(ack5), 32'(1));
      check("n1_soft_dom", 32'(dom5), 32'(0));
      #1 soft5 = 0;
      @(negedge clk);
      check("n1_soft_ack2", 32'(ack5), 32'(0));
      check("n1_soft_hold", 32'(dom5), 32'(0));
      @(negedge clk);
      check("n1_soft_rel", 32'(dom5), 32'(1));
      check("n1_soft_all", 32'(all5), 32'(1));

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
